// File: rtl/sonar_pkg.sv
// sonar_pkg: shared definitions for the sonar emulator and measurement path.
// Holds the FSM state encoding and the default timing constants. The same
// constants are used by the measurement side for its cm conversion. Also
// holds the helper that maps a sampled distance to the echo length in cm.
package sonar_pkg;

  typedef enum logic [2:0] {
    ESPERA_BAIXO = 3'd0,
    ESPERA       = 3'd1,
    CONTA_TRIG   = 3'd2,
    ATRASO       = 3'd3,
    ECO          = 3'd4,
    PAUSA        = 3'd5
  } estado_t;

  localparam int CYCLES_PER_CM_DEF   = 2941;
  localparam int TRIG_MIN_CYCLES_DEF = 500;
  localparam int DELAY_CYCLES_DEF    = 20000;
  localparam int MAX_CM_DEF          = 400;
  localparam int TIMEOUT_CM_DEF      = 646;
  localparam int HOLDOFF_CYCLES_DEF  = 500000;

  // Distances outside 1..max_cm answer with the timeout-length echo.
  function automatic logic dist_invalida(input logic [8:0] d, input int max_cm);
    return (d == 9'd0) || (int'(d) > max_cm);
  endfunction

  function automatic logic [9:0] calc_n_cm(input logic [8:0] d, input int max_cm,
                                           input int timeout_cm);
    if (dist_invalida(d, max_cm)) return 10'(timeout_cm);
    else return 10'(d);
  endfunction

endpackage

// File: rtl/sonar_emulador_contador_cm.sv
// contador_cm: echo length counter built without a multiplier.
// A 12-bit cycle counter wraps at CYCLES_PER_CM-1; each wrap advances a
// 10-bit cm counter. fim flags the wrap that brings the cm count to n_cm,
// so the enable window lasts exactly n_cm * CYCLES_PER_CM cycles.
// Ports:
//   clock    in  system clock
//   reset    in  asynchronous active-low reset
//   habilita in  count enable
//   limpa    in  synchronous clear (wins over habilita)
//   n_cm     in  target length in cm (must be >= 1)
//   fim      out end-of-count flag, combinational
module contador_cm #(
  parameter int CYCLES_PER_CM = 2941
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       limpa,
  input  logic [9:0] n_cm,
  output logic       fim
);

  logic [11:0] ciclos;
  logic [9:0]  cm;
  logic        volta;

  assign volta = (ciclos == 12'(CYCLES_PER_CM - 1));
  assign fim   = habilita && volta && ((cm + 10'd1) == n_cm);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ciclos <= '0;
      cm     <= '0;
    end else if (limpa) begin
      ciclos <= '0;
      cm     <= '0;
    end else if (habilita) begin
      if (volta) begin
        ciclos <= '0;
        cm     <= cm + 10'd1;
      end else begin
        ciclos <= ciclos + 12'd1;
      end
    end
  end

endmodule

// File: rtl/sonar_emulador.sv
// sonar_emulador: HC-SR04 responder model. Qualifies a trigger pulse and
// answers with an echo whose width encodes the distance sampled at T0.
// Ports:
//   clock        in  system clock (50 MHz)
//   reset        in  asynchronous active-low reset
//   trigger      in  trigger, asynchronous (2-FF synchronized)
//   distancia_cm in  distance to emulate, sampled at T0
//   echo         out echo pulse, registered
//   ocupado      out busy from T0 until the end of holdoff
//   erro         out one-cycle pulse at echo fall for an invalid distance
//
// state        | meaning
// ESPERA_BAIXO | wait for trig_s low before arming
// ESPERA       | armed, wait for trig_s rise
// CONTA_TRIG   | measure trigger width (saturating)
// ATRASO       | delay from T0 to echo
// ECO          | echo active
// PAUSA        | holdoff dead time
module sonar_emulador
  import sonar_pkg::*;
#(
  parameter int CYCLES_PER_CM   = CYCLES_PER_CM_DEF,
  parameter int TRIG_MIN_CYCLES = TRIG_MIN_CYCLES_DEF,
  parameter int DELAY_CYCLES    = DELAY_CYCLES_DEF,
  parameter int MAX_CM          = MAX_CM_DEF,
  parameter int TIMEOUT_CM      = TIMEOUT_CM_DEF,
  parameter int HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia_cm,
  output logic       echo,
  output logic       ocupado,
  output logic       erro
);

  estado_t     estado, prox;
  logic        trig_meta, trig_s;
  logic [18:0] cont;
  logic [8:0]  dist_lat;
  logic [9:0]  n_cm;
  logic        invalido;
  logic        trig_ok;
  logic        fim_cm;
  logic        echo_d, ocupado_d, erro_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
    end else begin
      trig_meta <= trigger;
      trig_s    <= trig_meta;
    end
  end

  assign trig_ok  = (cont >= 19'(TRIG_MIN_CYCLES));
  assign n_cm     = calc_n_cm(dist_lat, MAX_CM, TIMEOUT_CM);
  assign invalido = dist_invalida(dist_lat, MAX_CM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= ESPERA_BAIXO;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      ESPERA_BAIXO: if (!trig_s) prox = ESPERA;
      ESPERA:       if (trig_s) prox = CONTA_TRIG;
      CONTA_TRIG:   if (!trig_s) prox = trig_ok ? ATRASO : ESPERA;
      ATRASO:       if (cont == '0) prox = ECO;
      ECO:          if (fim_cm) prox = PAUSA;
      PAUSA:        if (cont == '0) prox = ESPERA_BAIXO;
      default:      prox = ESPERA_BAIXO;
    endcase
  end

  always_comb begin
    echo_d    = 1'b0;
    ocupado_d = 1'b0;
    case (estado)
      ATRASO: ocupado_d = 1'b1;
      ECO: begin
        echo_d    = 1'b1;
        ocupado_d = 1'b1;
      end
      PAUSA:  ocupado_d = 1'b1;
      default: ;
    endcase
    // echo still shows the last ECO cycle while the state has moved on,
    // which lands erro on the first echo=0 cycle.
    erro_d = echo && (estado != ECO) && invalido;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo    <= 1'b0;
      ocupado <= 1'b0;
      erro    <= 1'b0;
    end else begin
      echo    <= echo_d;
      ocupado <= ocupado_d;
      erro    <= erro_d;
    end
  end

  // Shared counter: trigger width (up), then delay and holdoff as
  // down-counters loaded with length-1 and ended at terminal count 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont     <= '0;
      dist_lat <= '0;
    end else begin
      case (estado)
        // The sample that moves us to CONTA_TRIG is already a high cycle.
        ESPERA: cont <= 19'd1;
        CONTA_TRIG: begin
          if (!trig_s) begin
            cont <= 19'(DELAY_CYCLES - 1);
            if (trig_ok) dist_lat <= distancia_cm;
          end else if (!trig_ok) begin
            cont <= cont + 19'd1;
          end
        end
        ATRASO: if (cont != '0) cont <= cont - 19'd1;
        ECO:    cont <= 19'(HOLDOFF_CYCLES - 1);
        PAUSA:  if (cont != '0) cont <= cont - 19'd1;
        default: cont <= '0;
      endcase
    end
  end

  contador_cm #(
    .CYCLES_PER_CM(CYCLES_PER_CM)
  ) u_contador_cm (
    .clock   (clock),
    .reset   (reset),
    .habilita(estado == ECO),
    .limpa   (estado != ECO),
    .n_cm    (n_cm),
    .fim     (fim_cm)
  );

endmodule
